// File: rtl/opr_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opr_phase_sequencer_pkg
// Description : Shared types and timing constants for the execution-phase
//               sequencer and the instruction decoders that consume it.
// Revision    : 1.0 - initial release
// ============================================================================
package opr_phase_sequencer_pkg;

    localparam int NUM_PHASES = 6;

    // Default phase timing, also used by decoder benches
    localparam int DEF_CK_CYCLES  = 2;
    localparam int DEF_STB_CYCLES = 1;
    localparam int DEF_GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

    // Phase index 1..6; 0 means no phase
    typedef logic [2:0] phase_idx_t;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opr_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : opr_phase_sequencer_if
// Description : Run/step control, decoder done feedback and phase outputs
//               shared between the sequencer and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
interface opr_phase_sequencer_if;

    logic run;
    logic step;
    logic done;
    logic ck1, ck2, ck3, ck4, ck5, ck6;
    logic stb1, stb2, stb3, stb4, stb5, stb6;
    logic instr_start;
    logic busy;
    logic seq_error;

    // Sequencer side
    modport master (
        input  run, step, done,
        output ck1, ck2, ck3, ck4, ck5, ck6,
        output stb1, stb2, stb3, stb4, stb5, stb6,
        output instr_start, busy, seq_error
    );

    // Front panel / decoder side
    modport slave (
        output run, step, done,
        input  ck1, ck2, ck3, ck4, ck5, ck6,
        input  stb1, stb2, stb3, stb4, stb5, stb6,
        input  instr_start, busy, seq_error
    );

endinterface
`default_nettype wire

// File: rtl/opr_phase_sequencer_phase_decoder.sv
`default_nettype none
// ============================================================================
// Module      : opr_phase_sequencer_phase_decoder
// Description : Maps (state, phase index, sub-count) to one-hot ck and stb.
//               stbN is only ever raised together with ckN.
// Revision    : 1.0 - initial release
// ============================================================================
module opr_phase_sequencer_phase_decoder
    import opr_phase_sequencer_pkg::*;
#(
    parameter int CK_CYCLES = DEF_CK_CYCLES,
    parameter int SUB_W     = 2
) (
    input  seq_state_t              state,
    input  phase_idx_t              phase,
    input  logic [SUB_W-1:0]        sub,
    output logic [NUM_PHASES-1:0]   ck,
    output logic [NUM_PHASES-1:0]   stb
);

    localparam logic [SUB_W-1:0] STB_FROM = SUB_W'(CK_CYCLES);

    logic w_active;
    logic w_strobe;

    assign w_active = (state == ST_PHASE);
    assign w_strobe = (sub >= STB_FROM);

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase
        assign ck[g]  = w_active && (phase == phase_idx_t'(g + 1));
        assign stb[g] = ck[g] && w_strobe;
    end

endmodule
`default_nettype wire

// File: rtl/opr_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : opr_phase_sequencer
// Description : Master timing generator producing six execution phases
//               (ck/stb per phase), ending an instruction on decoder done
//               and chaining the next one while run is high.
// Revision    : 1.0 - initial release
// ============================================================================
module opr_phase_sequencer
    import opr_phase_sequencer_pkg::*;
#(
    parameter int CK_CYCLES  = DEF_CK_CYCLES,
    parameter int STB_CYCLES = DEF_STB_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    opr_phase_sequencer_if.master   bus
);

    localparam int PHASE_CYCLES = CK_CYCLES + STB_CYCLES;
    localparam int SUB_W        = cnt_width(PHASE_CYCLES);
    localparam int GAP_W        = cnt_width(GAP_CYCLES);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(PHASE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam phase_idx_t       LAST_PHASE = phase_idx_t'(NUM_PHASES);

    seq_state_t        r_state, w_state;
    phase_idx_t        r_phase, w_phase;
    logic [SUB_W-1:0]  r_sub,   w_sub;
    logic [GAP_W-1:0]  r_gap,   w_gap;
    logic              r_err,   w_err;
    logic              w_to_gap, w_finish, w_start, w_set_err;
    logic [NUM_PHASES-1:0] w_ck, w_stb;

    // State register; asynchronous reset drops every output immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_sub   <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_sub   <= w_sub;
            r_gap   <= w_gap;
            r_err   <= w_err;
        end
    end

    // Next-state: phase stepping, early end on done, gap, restart on run
    always_comb begin
        w_state   = r_state;
        w_phase   = r_phase;
        w_sub     = r_sub;
        w_gap     = r_gap;
        w_err     = r_err;
        w_to_gap  = 1'b0;
        w_finish  = 1'b0;
        w_start   = 1'b0;
        w_set_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_start = bus.run || bus.step;
            end
            ST_PHASE: begin
                if (bus.done) begin
                    w_to_gap = 1'b1;
                end else if (r_sub == SUB_LAST) begin
                    if (r_phase == LAST_PHASE) begin
                        w_set_err = 1'b1;
                        w_to_gap  = 1'b1;
                    end else begin
                        w_phase = phase_idx_t'(r_phase + 3'd1);
                        w_sub   = '0;
                    end
                end else begin
                    w_sub = r_sub + SUB_W'(1);
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_finish = 1'b1;
                end else begin
                    w_gap = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // With no gap the instruction ends in the same cycle it leaves PHASE
        if (w_to_gap) begin
            if (GAP_CYCLES == 0) begin
                w_finish = 1'b1;
            end else begin
                w_state = ST_GAP;
                w_gap   = '0;
            end
        end

        if (w_finish) begin
            if (bus.run) begin
                w_start = 1'b1;
            end else begin
                w_state = ST_IDLE;
                w_phase = '0;
                w_sub   = '0;
                w_gap   = '0;
            end
        end

        if (w_start) begin
            w_state = ST_PHASE;
            w_phase = phase_idx_t'(1);
            w_sub   = '0;
            w_gap   = '0;
            w_err   = 1'b0;
        end

        // A fresh error wins over the clear, so it stays visible for at
        // least one instruction even when the next one starts immediately
        if (w_set_err) begin
            w_err = 1'b1;
        end
    end

    opr_phase_sequencer_phase_decoder #(
        .CK_CYCLES (CK_CYCLES),
        .SUB_W     (SUB_W)
    ) u_phase_decoder (
        .state (r_state),
        .phase (r_phase),
        .sub   (r_sub),
        .ck    (w_ck),
        .stb   (w_stb)
    );

    assign bus.ck1  = w_ck[0];
    assign bus.ck2  = w_ck[1];
    assign bus.ck3  = w_ck[2];
    assign bus.ck4  = w_ck[3];
    assign bus.ck5  = w_ck[4];
    assign bus.ck6  = w_ck[5];
    assign bus.stb1 = w_stb[0];
    assign bus.stb2 = w_stb[1];
    assign bus.stb3 = w_stb[2];
    assign bus.stb4 = w_stb[3];
    assign bus.stb5 = w_stb[4];
    assign bus.stb6 = w_stb[5];

    assign bus.instr_start = (r_state == ST_PHASE) && (r_phase == phase_idx_t'(1))
                             && (r_sub == '0);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.seq_error   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_opr_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_opr_phase_sequencer
// Description : Directed bench for opr_phase_sequencer; default timing on
//               one instance, CK=1/STB=2/GAP=0 on a second.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opr_phase_sequencer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    opr_phase_sequencer_if bus_a ();
    opr_phase_sequencer_if bus_b ();

    opr_phase_sequencer #(
        .CK_CYCLES (2), .STB_CYCLES (1), .GAP_CYCLES (1)
    ) dut_a (
        .clk (clk), .reset_n (reset_n), .bus (bus_a)
    );

    opr_phase_sequencer #(
        .CK_CYCLES (1), .STB_CYCLES (2), .GAP_CYCLES (0)
    ) dut_b (
        .clk (clk), .reset_n (reset_n), .bus (bus_b)
    );

    // Decoder stand-in: done follows the ck of the selected phase (0 = never)
    int dp_a, dp_b;
    logic [5:0] ck_a, stb_a, ck_b, stb_b;
    logic [14:0] obs_a, obs_b;

    assign ck_a  = {bus_a.ck6, bus_a.ck5, bus_a.ck4, bus_a.ck3, bus_a.ck2, bus_a.ck1};
    assign stb_a = {bus_a.stb6, bus_a.stb5, bus_a.stb4, bus_a.stb3, bus_a.stb2, bus_a.stb1};
    assign ck_b  = {bus_b.ck6, bus_b.ck5, bus_b.ck4, bus_b.ck3, bus_b.ck2, bus_b.ck1};
    assign stb_b = {bus_b.stb6, bus_b.stb5, bus_b.stb4, bus_b.stb3, bus_b.stb2, bus_b.stb1};
    assign obs_a = {bus_a.seq_error, bus_a.busy, bus_a.instr_start, stb_a, ck_a};
    assign obs_b = {bus_b.seq_error, bus_b.busy, bus_b.instr_start, stb_b, ck_b};

    always_comb begin
        bus_a.done = 1'b0;
        bus_b.done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (dp_a == i + 1 && ck_a[i]) bus_a.done = 1'b1;
            if (dp_b == i + 1 && ck_b[i]) bus_b.done = 1'b1;
        end
    end

    // Expected vector: {seq_error, busy, instr_start, stb[6], ck[6]}
    logic [14:0] exp_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    string tag;
    bit    sel;

    // n_issue cycles of phase k, stb after n_ck cycles
    task automatic push_ph(input int k, input int n_ck, input int n_issue, input bit err);
        logic [5:0] oh;
        oh = 6'(1) << (k - 1);
        for (int c = 0; c < n_issue; c++)
            exp_q.push_back({err, 1'b1, (k == 1 && c == 0), (c >= n_ck) ? oh : 6'd0, oh});
    endtask

    task automatic push_quiet(input int n, input bit busy, input bit err);
        for (int c = 0; c < n; c++)
            exp_q.push_back({err, busy, 1'b0, 6'd0, 6'd0});
    endtask

    task automatic check_now();
        logic [14:0] e, o;
        e = exp_q.pop_front();
        o = sel ? obs_b : obs_a;
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h (err,busy,start,stb,ck)", tag, o, e);
        end
    endtask

    task automatic check_cycle();
        @(posedge clk);
        #1;
        check_now();
    endtask

    // Drains the queue one clock per entry; step lasts one edge, run drops at drop_at
    task automatic run_q(input int drop_at);
        int i;
        i = 0;
        while (exp_q.size() > 0) begin
            if (i == drop_at) begin
                bus_a.run = 1'b0;
                bus_b.run = 1'b0;
            end
            if (i == 1) begin
                bus_a.step = 1'b0;
                bus_b.step = 1'b0;
            end
            check_cycle();
            i++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        bus_a.run  = 1'b0;
        bus_a.step = 1'b0;
        bus_b.run  = 1'b0;
        bus_b.step = 1'b0;
        dp_a = 0;
        dp_b = 0;
        sel  = 1'b0;

        #12;
        tag = "reset_state";
        push_quiet(1, 1'b0, 1'b0);
        check_now();
        reset_n = 1'b1;

        // Single OPR group 1: done on first ck2
        tag = "step_done_ck2";
        dp_a = 2;
        bus_a.step = 1'b1;
        push_ph(1, 2, 3, 1'b0);
        push_ph(2, 2, 1, 1'b0);
        push_quiet(1, 1'b1, 1'b0);
        push_quiet(2, 1'b0, 1'b0);
        run_q(-1);

        // Back-to-back, done on ck3, 8-clock period
        tag = "run_done_ck3";
        dp_a = 3;
        bus_a.run = 1'b1;
        for (int n = 0; n < 2; n++) begin
            push_ph(1, 2, 3, 1'b0);
            push_ph(2, 2, 3, 1'b0);
            push_ph(3, 2, 1, 1'b0);
            push_quiet(1, 1'b1, 1'b0);
        end
        push_quiet(1, 1'b0, 1'b0);
        run_q(16);

        // No done: all six phases, then sticky error
        tag = "step_no_done";
        dp_a = 0;
        bus_a.step = 1'b1;
        for (int k = 1; k <= 6; k++) push_ph(k, 2, 3, 1'b0);
        push_quiet(1, 1'b1, 1'b1);
        push_quiet(2, 1'b0, 1'b1);
        run_q(-1);

        tag = "err_clear_on_start";
        dp_a = 1;
        bus_a.step = 1'b1;
        push_ph(1, 2, 1, 1'b0);
        push_quiet(1, 1'b1, 1'b0);
        push_quiet(1, 1'b0, 1'b0);
        run_q(-1);

        // run drops during ck2 of a 4-phase instruction
        tag = "run_drop_ck2";
        dp_a = 4;
        bus_a.run = 1'b1;
        push_ph(1, 2, 3, 1'b0);
        push_ph(2, 2, 3, 1'b0);
        push_ph(3, 2, 3, 1'b0);
        push_ph(4, 2, 1, 1'b0);
        push_quiet(1, 1'b1, 1'b0);
        push_quiet(2, 1'b0, 1'b0);
        run_q(4);

        // Reset mid-stb3 with no clock edge
        tag = "run_to_stb3";
        dp_a = 0;
        bus_a.run = 1'b1;
        push_ph(1, 2, 3, 1'b0);
        push_ph(2, 2, 3, 1'b0);
        push_ph(3, 2, 3, 1'b0);
        run_q(-1);
        #2;
        reset_n = 1'b0;
        #1;
        tag = "async_reset_mid_stb3";
        push_quiet(1, 1'b0, 1'b0);
        check_now();
        @(negedge clk);
        dp_a = 1;
        reset_n = 1'b1;
        tag = "restart_after_reset";
        push_ph(1, 2, 1, 1'b0);
        push_quiet(1, 1'b1, 1'b0);
        push_quiet(1, 1'b0, 1'b0);
        run_q(1);

        // Second instance: CK=1, STB=2, GAP=0, done on ck2
        tag = "ck1_stb2_gap0";
        sel = 1'b1;
        dp_b = 2;
        bus_b.run = 1'b1;
        for (int n = 0; n < 2; n++) begin
            push_ph(1, 1, 3, 1'b0);
            push_ph(2, 1, 1, 1'b0);
        end
        push_quiet(1, 1'b0, 1'b0);
        run_q(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
